// File: rtl/seq_subtractor_if.sv
// Operand/result bundle for the byte-serial subtractor.
// The slave side is the subtractor itself; the master side issues requests.
interface seq_subtractor_if;
  logic        start;
  logic [31:0] in_1;
  logic [31:0] in_2;
  logic        busy;
  logic        done;
  logic [31:0] out_1;
  logic        borrow;

  modport slave (
    input  start, in_1, in_2,
    output busy, done, out_1, borrow
  );

  modport master (
    output start, in_1, in_2,
    input  busy, done, out_1, borrow
  );
endinterface

// File: rtl/seq_subtractor.sv
// 32-bit subtractor that resolves one byte per clock, LSB first, with a
// running borrow; results appear on the completing edge and then hold.
module seq_subtractor (
  input  logic             clk,
  input  logic             rst_n,
  seq_subtractor_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] a_q, b_q, acc;
  logic        br;
  logic [1:0]  cnt;
  logic [31:0] res_q;
  logic        res_br_q;
  logic        busy_c, done_c;

  logic        accept;
  logic        last;
  logic [4:0]  lsb;
  logic [7:0]  a_byte, b_byte;
  logic [8:0]  diff;

  assign accept = bus.start && (state == IDLE || state == DONE);
  assign last   = (state == RUN) && (cnt == 2'd3);
  assign lsb    = {cnt, 3'b000};

  // Bit 8 of the 9-bit difference is the borrow out of this byte.
  always_comb begin
    a_byte = a_q[lsb +: 8];
    b_byte = b_q[lsb +: 8];
    diff   = {1'b0, a_byte} - {1'b0, b_byte} - {8'd0, br};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = bus.start ? RUN : IDLE;
      RUN:     state_nxt = (cnt == 2'd3) ? DONE : RUN;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state)
      RUN:     busy_c = 1'b1;
      DONE:    done_c = 1'b1;
      default: ;
    endcase
  end

  // Operand capture and byte-serial datapath; RUN ignores start entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= 32'd0;
      b_q <= 32'd0;
      acc <= 32'd0;
      br  <= 1'b0;
      cnt <= 2'd0;
    end else if (accept) begin
      a_q <= bus.in_1;
      b_q <= bus.in_2;
      acc <= 32'd0;
      br  <= 1'b0;
      cnt <= 2'd0;
    end else if (state == RUN) begin
      acc[lsb +: 8] <= diff[7:0];
      br            <= diff[8];
      cnt           <= cnt + 2'd1;
    end
  end

  // Visible result only moves on the completing edge, so it holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q    <= 32'd0;
      res_br_q <= 1'b0;
    end else if (last) begin
      res_q    <= {diff[7:0], acc[23:0]};
      res_br_q <= diff[8];
    end
  end

  assign bus.busy   = busy_c;
  assign bus.done   = done_c;
  assign bus.out_1  = res_q;
  assign bus.borrow = res_br_q;

endmodule

// File: doc/seq_subtractor.md
# seq_subtractor

Multi-cycle 32-bit subtractor computing out_1 = in_1 - in_2 one byte per clock, least-significant byte first, with a start/done handshake. It is the inverse datapath companion to the team's 32-bit combinational adder and uses the same operand and result naming. It is intended for narrow-datapath contexts where a full-width borrow chain is not wanted in one cycle.

## Interface
- No parameters. Width is fixed at 32 bits, processed as 4 bytes.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on the rising edge; accepted only in IDLE or DONE.
- in_1  input  32  minuend; captured on the accepting edge.
- in_2  input  32  subtrahend; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; high exactly while in DONE.
- out_1  output  32  difference modulo 2^32; changes only on the completing edge or on reset.
- borrow  output  1  final borrow, 1 iff in_1 < in_2 (unsigned); same update rule as out_1.

## Operation
- States are IDLE, RUN and DONE. Internal registers:
  - a_q[31:0] and b_q[31:0]: captured operands.
  - acc[31:0]: partial result.
  - br: running borrow.
  - cnt[1:0]: byte index.
- IDLE:
  - start=1 captures in_1 into a_q and in_2 into b_q.
  - Clears acc, clears br, sets cnt=0, moves to RUN.
  - start=0 stays in IDLE.
- RUN, each edge:
  - Computes the 9-bit value {1'b0,a_q[8k+7:8k]} - {1'b0,b_q[8k+7:8k]} - br, where k=cnt.
  - Writes the low 8 bits to acc[8k+7:8k]. br takes bit 8 of the 9-bit result.
  - cnt increments.
  - When cnt==3: transfers {new byte, acc[23:0]} to out_1 and the new borrow to borrow, then moves to DONE.
- RUN ignores start. Operands already captured are unaffected by later changes on in_1 and in_2.
- DONE lasts one cycle.
  - start=1 is accepted as in IDLE, for back-to-back operation, and the next state is RUN.
  - Otherwise the next state is IDLE.
- out_1 and borrow hold their last result indefinitely until the next completion.
- Arithmetic is unsigned and wraps modulo 2^32. The borrow propagates across all 4 bytes.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, out_1=0, borrow=0, and all internal registers cleared.
- Reset asserted mid-RUN or in DONE aborts the operation. out_1 and borrow return to 0 immediately; no done pulse follows.
- Latency, with edge E0 as the accepting edge:
  - busy=1 after E0, through E4.
  - Bytes are computed on E1 through E4.
  - out_1, borrow and done=1 update on E4.
  - done returns to 0 on E5 unless a new start was accepted on E5. Even then done=0 after E5, because the state is RUN.
- Throughput: one result per 5 cycles with start held high continuously; one result per 5 cycles minimum in any case.
- A start pulse arriving during RUN is dropped, not queued.

## Test plan
- Reset, then A=0x00AD3EF0, B=0x00E78FF5, start pulsed for 1 cycle:
  - done pulses exactly 4 edges after acceptance.
  - out_1=0xFFC5AEFB, borrow=1.
  - busy high for 4 cycles.
- A=0x007EFED3, B=0x0060DF26 -> out_1=0x001E1FAD, borrow=0. Then A=0x00DDEDF9, B=0x00DDEDF9 -> out_1=0, borrow=0.
- Borrow-ripple corner cases:
  - A=0x00000000, B=0x00000001 -> out_1=0xFFFFFFFF, borrow=1.
  - A=0x80000000, B=0x00000001 -> out_1=0x7FFFFFFF, borrow=0.
- start held high for 15 cycles with operands changing every cycle:
  - Exactly 3 done pulses, spaced 5 cycles apart.
  - Each result matches the operands present on its accepting edge.
  - Operand changes during RUN have no effect.
- Reset mid-operation: assert rst_n=0 asynchronously between edges at E2.
  - out_1, borrow, busy and done all go to 0 immediately, with no done pulse.
  - After release, a new start with A=0x0068EFAD, B=0x00EF123D yields out_1=0xFF79DD70, borrow=1.
- Hold check: after a completion, idle for 10 cycles with in_1 and in_2 toggling and start=0. out_1 and borrow remain constant, and done stays 0.
